// File: rtl/exec_datapath.sv
// exec_datapath: ALU, operand mux, 32-word data memory and writeback mux behind the control unit
module exec_datapath #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  zero
);
  logic [DATA_WIDTH-1:0] b, alu, alu_reg, mem_rdata;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0]  addr;
  assign b       = sel3 ? offset : operand2;
  assign addr    = alu_reg[ADDR_BITS-1:0];
  assign result2 = sel1 ? alu_reg : mem_rdata;
  // ALU; unused opcodes (including the reset opcode 15) produce zero
  always_comb begin
    alu = '0;
    case (opcode)
      4'd0: alu = operand1 + b;
      4'd1: alu = operand1 - b;
      4'd2: alu = operand1 & b;
      4'd3: alu = operand1 | b;
      4'd4: alu = operand1 ^ b;
      4'd5: alu = ~operand1;
      4'd6: alu = {operand1[DATA_WIDTH-2:0], 1'b0};
      4'd7: alu = {1'b0, operand1[DATA_WIDTH-1:1]};
      4'd8: alu = b;
      default: alu = '0;
    endcase
  end
  // ALU register, zero flag and memory; reset reloads mem[i]=i and blocks any store in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_reg   <= '0;
      zero      <= 1'b1;
      mem_rdata <= '0;
      for (int i = 0; i < 2**ADDR_BITS; i++) mem[i[ADDR_BITS-1:0]] <= DATA_WIDTH'(i);
    end else begin
      alu_reg   <= alu;
      zero      <= (alu == '0);
      mem_rdata <= mem[addr];
      if (w_r) mem[addr] <= operand2;
    end
  end
endmodule

// File: tb/tb_exec_datapath.sv
// tb_exec_datapath: directed scoreboard bench for exec_datapath
module tb_exec_datapath;
  logic       clk = 1'b0;
  logic       rst, sel1, sel3, w_r, zero;
  logic [7:0] operand1, operand2, offset, result2;
  logic [3:0] opcode;
  int         total = 0, passed = 0, fails = 0;
  logic [7:0] exp_q [$];
  string      tag_q [$];

  exec_datapath dut (
    .clk(clk), .rst(rst), .operand1(operand1), .operand2(operand2), .offset(offset),
    .opcode(opcode), .sel1(sel1), .sel3(sel3), .w_r(w_r), .result2(result2), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_check();
    string      tag;
    logic [7:0] exp;
    tag = tag_q.size() ? tag_q.pop_front() : "empty_queue";
    exp = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    chk(tag, result2, exp);
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] bb, input logic [7:0] off,
                       input logic [3:0] op, input logic s3, input logic s1);
    operand1 = a; operand2 = bb; offset = off; opcode = op; sel3 = s3; sel1 = s1;
  endtask

  logic [3:0] t_op [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  logic [7:0] t_ex [8] = '{8'h00, 8'hFF, 8'hFF, 8'h3A, 8'h8A, 8'h62, 8'h3A, 8'h00};

  initial begin
    rst = 1'b1; w_r = 1'b1;
    drive(8'h00, 8'hFF, 8'h00, 4'hF, 1'b0, 1'b1);
    step(2);
    rst = 1'b0; w_r = 1'b0;
    chk("reset_result2_sel1", result2, 8'h00);
    chk("reset_zero", {7'b0, zero}, 8'h01);
    sel1 = 1'b0; #1;
    chk("reset_result2_sel0", result2, 8'h00);

    drive(8'd4, 8'hFF, 8'd5, 4'd0, 1'b1, 1'b0);
    push("reset_load9", 8'd9);
    step(2); pop_check();

    drive(8'd2, 8'd3, 8'd0, 4'd0, 1'b0, 1'b1);
    push("add_2_3", 8'd5);
    step(); pop_check();
    chk("add_zero", {7'b0, zero}, 8'h00);

    drive(8'd1, 8'd2, 8'd0, 4'd1, 1'b0, 1'b1);
    push("sub_wrap", 8'hFF);
    step(); pop_check();
    drive(8'd3, 8'd3, 8'd0, 4'd1, 1'b0, 1'b1);
    push("sub_zero", 8'h00);
    step(); pop_check();
    chk("sub_zero_flag", {7'b0, zero}, 8'h01);

    for (int i = 0; i < 8; i++) begin
      drive(8'hC5, 8'h3A, 8'h11, t_op[i], 1'b0, 1'b1);
      push($sformatf("alu_op%0d", t_op[i]), t_ex[i]);
      step(); pop_check();
      chk($sformatf("alu_op%0d_zero", t_op[i]), {7'b0, zero}, {7'b0, t_ex[i] == 8'h00});
    end
    drive(8'hC5, 8'h3A, 8'h11, 4'd8, 1'b1, 1'b1);
    push("passb_offset", 8'h11);
    step(); pop_check();

    drive(8'd3, 8'd3, 8'd0, 4'hF, 1'b0, 1'b1);
    push("opcode15", 8'h00);
    step(); pop_check();

    drive(8'd2, 8'd0, 8'd5, 4'd0, 1'b1, 1'b0);
    push("load7_early", 8'd0);
    push("load7", 8'd7);
    step(); pop_check();
    step(); pop_check();

    drive(8'd1, 8'hAA, 8'd3, 4'd0, 1'b1, 1'b0);
    step();
    w_r = 1'b1;
    push("store_rdw_old", 8'd4);
    step(); pop_check();
    w_r = 1'b0;
    push("store_readback", 8'hAA);
    step(); pop_check();
    drive(8'd2, 8'h00, 8'd3, 4'd0, 1'b1, 1'b0);
    push("load5_untouched", 8'd5);
    step(2); pop_check();

    drive(8'd30, 8'h00, 8'd5, 4'd0, 1'b1, 1'b0);
    push("wrap_load3", 8'd3);
    step(2); pop_check();
    operand2 = 8'h55; w_r = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; w_r = 1'b0;
    chk("midstore_rst_rdata", result2, 8'h00);
    chk("midstore_rst_zero", {7'b0, zero}, 8'h01);
    push("midstore_mem3", 8'd3);
    step(2); pop_check();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/exec_datapath.md
# exec_datapath

Execution datapath that answers the control unit's operand/control interface. It holds the ALU, the ALU-B operand mux, a 32-entry data memory and the writeback mux. It consumes `operand1`, `operand2`, `offset`, `opcode`, `sel1`, `sel3` and `w_r` and returns `result2`, which the control unit samples in its WRITE_BACK state. The block has no FSM of its own; its sequencing is fixed pipeline latency that matches the control unit's DECODE→EXECUTE→(MEM_ACCESS)→WRITE_BACK walk.

## Interface
- DATA_WIDTH, 8, operand/result/memory word width
- ADDR_BITS, 5, data memory address width (2^ADDR_BITS words)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- operand1  in  DATA_WIDTH  ALU A input (X2)
- operand2  in  DATA_WIDTH  ALU B candidate (X3) and store data (X1)
- offset  in  DATA_WIDTH  ALU B candidate for address generation
- opcode  in  4  ALU operation
- sel1  in  1  1: result2 from ALU register; 0: from memory read data
- sel3  in  1  1: ALU B = offset; 0: ALU B = operand2
- w_r  in  1  memory write enable
- result2  out  DATA_WIDTH  writeback value to control unit
- zero  out  1  registered flag, 1 when ALU register is 0

## Operation
- ALU B = sel3 ? offset : operand2.
- ALU opcodes, with all arithmetic mod 2^DATA_WIDTH and carries discarded:
  - 0 ADD A+B
  - 1 SUB A−B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 A<<1
  - 7 A>>1 (logical)
  - 8 pass B
  - 9–15 yield 0. This includes reset opcode 4'b1111.
- alu_reg <= ALU(A,B) on every non-reset edge. zero <= (ALU(A,B)==0) on the same edge.
- Memory address = alu_reg[ADDR_BITS-1:0]. Upper bits are ignored, so addresses wrap modulo 2^ADDR_BITS.
- Write: on an edge with w_r=1 and rst=0, mem[addr] <= operand2.
- Read: mem_rdata <= mem[addr] on every non-reset edge.
- Read during write to the same address returns the old data.
- result2 = sel1 ? alu_reg : mem_rdata. This is combinational from registers and the sel1 input.
- Reset (rst=1 at edge):
  - alu_reg=0, zero=1, mem_rdata=0.
  - mem[i] <= i[DATA_WIDTH-1:0] for all i.
  - Writes are suppressed even if w_r=1.
  - This holds regardless of operation in flight; a partially completed load or store is abandoned.

## Timing
- ALU result (sel1=1): valid on result2 one cycle after operands/opcode/sel3 are presented.
  - For std_op the control unit drives operands at the DECODE edge and samples result2 at the WRITE_BACK edge, two edges later. Margin: one cycle.
- Load (sel3=1, sel1=0, opcode=ADD):
  - Edge N+1: alu_reg holds address.
  - Edge N+2: mem_rdata holds data.
  - result2 is valid after edge N+2, i.e. before the control unit's WRITE_BACK edge (N+3).
- Store: the address must be in alu_reg before the edge where w_r=1.
  - The control unit raises w_r in EXECUTE, so it is visible during the MEM_ACCESS cycle. The write commits at the edge ending MEM_ACCESS.
  - w_r is honoured for exactly the edges it is high. A multi-cycle w_r writes repeatedly to the current alu_reg address.
- Outputs during reset: result2 = 0 for either sel1 value; zero = 1.
- No backpressure and no handshake. Inputs are assumed to be held by the control unit for the full instruction.

## Test plan
- Reset: assert rst 2 cycles with w_r=1, operand2=0xFF. Then:
  - result2=0 and zero=1.
  - A load of addr 9 returns 9, proving no write occurred and mem is initialised.
- ADD: operand1=2, operand2=3, sel3=0, sel1=1, opcode=0 held → result2=5 one cycle later, zero=0.
- SUB wrap and zero:
  - 1−2 → result2=0xFF.
  - Then 3−3 → result2=0, zero=1.
  - opcode=15 → result2=0.
- Load: operand1=2, offset=5, sel3=1, sel1=0, opcode=0 → result2=7 (mem[7]) two edges after presentation. Check result2 is not yet 7 after one edge.
- Store then load:
  - operand1=1, offset=3, operand2=0xAA, opcode=0.
  - w_r=1 for one cycle after alu_reg=4 → mem[4]=0xAA.
  - A following load of address 4 returns 0xAA; address 5 still returns 5.
- Address wrap and reset mid-store:
  - operand1=30, offset=5 → load reads mem[3]=3.
  - A store to address 3 with rst asserted on the w_r edge leaves mem[3]=3.
